io_port_unit: RTL and testbench
===============================

// Module: io_port_unit
// PURPOSE
// - Responder side of the CPU I/O bus: decodes io_enable/io_write/io_addr from the control unit, serves port reads and accepts port writes.
// - Owns NPORTS synchronized input ports and NPORTS latched output ports with per-port strobe/ack handshake to external devices.
// - Sits between the datapath I/O mux and the chip pins; the CPU never stalls, and write overruns are flagged in a status register.
// PARAMETERS
// - WIDTH   8  data width of every port and of the bus
// - NPORTS  4  number of input ports and of output ports (power of 2, max 4)
// PORTS
// - clk        in   1             system clock, rising edge
// - reset      in   1             asynchronous, active-low reset
// - io_enable  in   1             bus access this cycle
// - io_write   in   1             1 = CPU writes port, 0 = CPU reads port
// - io_addr    in   3             [1:0] port index; [2]=1 selects status register (read only)
// - io_wdata   in   WIDTH         write data (register or immediate)
// - io_rdata   out  WIDTH         read data, combinational from registered state
// - in_data    in   NPORTS*WIDTH  asynchronous external inputs, port p = [p*WIDTH +: WIDTH]
// - out_data   out  NPORTS*WIDTH  latched output ports
// - out_stb    out  NPORTS        per-port "new data" strobe, level, held until acked
// - out_ack    in   NPORTS        per-port acknowledge from external device
// - irq        out  1             input-change interrupt (IO_IRQ_EN only; else 0)
// BEHAVIOUR
// - Reset (reset=0, async): out_data=0, out_stb=0, overrun=0, sync stages=0, irq flags=0; io_rdata=0.
// - Inputs: each in_data port passes a 2-flop synchronizer; reads see values 2 clk after pin change.
// - Read (io_enable=1, io_write=0, addr[2]=0): io_rdata = sync[addr[1:0]] same cycle; no state change except IRQ clear.
// - Status read (addr[2]=1): io_rdata = {overrun[3:0], out_stb[3:0]} (unused bits 0); reading clears overrun on the next edge.
// - Writes with addr[2]=1 are ignored; addr[1:0] >= NPORTS: read returns 0, write ignored.
// - Per-output-port FSM, 2 states:
//   - IDLE: out_stb=0; CPU write -> latch io_wdata into out_data[p], go PEND next edge.
//   - PEND: out_stb=1; out_ack[p]=1 -> IDLE; CPU write without ack -> relatch data, set overrun[p], stay PEND.
//   - PEND, write AND ack same cycle -> ack consumes old data, new data latched, stay PEND, overrun NOT set.
// - out_ack in IDLE is ignored. out_ack is assumed synchronous to clk.
// - Latency: write -> out_data/out_stb visible 1 clk after the write edge; ack -> out_stb low 1 clk later.
// - Overrun bits are sticky until a status read; a status read coinciding with a new overrun leaves that bit set.
// - Reset asserted mid-handshake: out_stb drops immediately, pending data lost.
// CONFIGURATION
// - Macro IO_IRQ_EN defined: per-port sticky flag set when sync[p] differs from its previous-cycle value;
//   irq = OR of flags; a read of port p clears flag p on the next edge (a change in the same cycle wins, flag stays set).
// - IO_IRQ_EN undefined: no change-detect registers, irq tied to 0, reads have no side effects on input ports.
// STRUCTURE
// - Package io_pkg: WIDTH/NPORTS defaults, address-field constants (IO_STATUS_BIT=2), FSM state encoding (ST_IDLE, ST_PEND).
// - Sub-module io_sync2: parameterized WIDTH two-flop synchronizer with async active-low reset, instanced per input port.
// - Output FSMs and status logic generated per port inside io_port_unit.
// TESTING
// - Reset: drive in_data=0xA5 per port, assert reset mid-run -> all outputs 0, out_stb=0 immediately.
// - Input sync: set in_data port1=0x3C -> read port1 returns 0x3C only from 2nd edge on, 0x00 before.
// - Handshake: write 0x55 to port2 -> out_data[2]=0x55, out_stb[2]=1 next clk; ack 1 cycle -> out_stb[2]=0.
// - Overrun: write 0x11 then 0x22 to port0 without ack -> out_data[0]=0x22, status read = 0x11; next status read = 0x01.
// - Write+ack same cycle on PEND port3 with 0x77 -> out_data[3]=0x77, out_stb[3]=1, overrun[3]=0.
// - IO_IRQ_EN: toggle in_data port0 0x00->0x01 -> irq=1 after 3 clk; read port0 -> irq=0 next clk; undefined macro -> irq stays 0.

Source files
------------

// File: rtl/io_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Brief    : Shared constants and state encoding for the CPU I/O port unit.
// Revision : 1.0
// ============================================================================
package io_pkg;

  localparam int IO_WIDTH_DEF  = 8;
  localparam int IO_NPORTS_DEF = 4;

  // io_addr[IO_STATUS_BIT] selects the read-only status register
  localparam int IO_STATUS_BIT = 2;
  localparam int IO_IDX_BITS   = 2;

  // Status word layout: out_stb in the low nibble, overrun flags above it
  localparam int IO_STB_LSB = 0;
  localparam int IO_OVR_LSB = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } port_state_e;

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_sync2
// Brief    : Two-flop synchronizer for an asynchronous WIDTH-bit input bus.
// Revision : 1.0
// ============================================================================
module io_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : io_sync2
`default_nettype wire

// File: rtl/io_port_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_port_unit
// Brief    : Responder for the CPU I/O bus: synchronized input ports, latched
//            output ports with strobe/ack handshake, sticky overrun status.
//            Define IO_IRQ_EN to add the input-change interrupt.
// Revision : 1.0
// ============================================================================
module io_port_unit
  import io_pkg::*;
#(
  parameter int WIDTH  = IO_WIDTH_DEF,
  parameter int NPORTS = IO_NPORTS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_enable,
  input  logic                    io_write,
  input  logic [2:0]              io_addr,
  input  logic [WIDTH-1:0]        io_wdata,
  output logic [WIDTH-1:0]        io_rdata,
  input  logic [NPORTS*WIDTH-1:0] in_data,
  output logic [NPORTS*WIDTH-1:0] out_data,
  output logic [NPORTS-1:0]       out_stb,
  input  logic [NPORTS-1:0]       out_ack,
  output logic                    irq
);

  logic                    stat_sel;
  logic [IO_IDX_BITS-1:0]  port_idx;
  logic                    bus_rd;
  logic                    bus_wr;
  logic                    stat_rd;
  logic [NPORTS*WIDTH-1:0] sync_bus;
  logic [NPORTS-1:0]       overrun;
  logic [WIDTH-1:0]        status;
`ifdef IO_IRQ_EN
  logic [NPORTS-1:0]       irq_flag;
`endif

  assign stat_sel = io_addr[IO_STATUS_BIT];
  assign port_idx = io_addr[IO_IDX_BITS-1:0];
  assign bus_rd   = io_enable & ~io_write;
  assign bus_wr   = io_enable & io_write & ~stat_sel;
  assign stat_rd  = bus_rd & stat_sel;

  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      port_state_e      state_q, state_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic             ovr_q, ovr_d;
      logic             wr_hit;

      io_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_data[p*WIDTH +: WIDTH]),
        .q     (sync_bus[p*WIDTH +: WIDTH])
      );

      assign wr_hit = bus_wr & (port_idx == IO_IDX_BITS'(p));

      // A write landing together with an ack hands the old data over, so
      // only a write against an un-acked pending value counts as overrun.
      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = ovr_q & ~stat_rd;
        case (state_q)
          ST_IDLE: begin
            if (wr_hit) begin
              data_d  = io_wdata;
              state_d = ST_PEND;
            end
          end
          ST_PEND: begin
            if (wr_hit) begin
              data_d = io_wdata;
              if (!out_ack[p]) ovr_d = 1'b1;
            end else if (out_ack[p]) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= ST_IDLE;
          data_q  <= '0;
          ovr_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
          ovr_q   <= ovr_d;
        end
      end

      assign out_data[p*WIDTH +: WIDTH] = data_q;
      assign out_stb[p]                 = (state_q == ST_PEND);
      assign overrun[p]                 = ovr_q;

`ifdef IO_IRQ_EN
      logic [WIDTH-1:0] prev_q, prev_d;
      logic             flag_q, flag_d;
      logic             rd_hit;

      assign rd_hit = bus_rd & ~stat_sel & (port_idx == IO_IDX_BITS'(p));

      // A change in the same cycle as the clearing read keeps the flag set.
      always_comb begin
        prev_d = sync_bus[p*WIDTH +: WIDTH];
        flag_d = (sync_bus[p*WIDTH +: WIDTH] != prev_q) | (flag_q & ~rd_hit);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prev_q <= '0;
          flag_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
          flag_q <= flag_d;
        end
      end

      assign irq_flag[p] = flag_q;
`endif
    end : g_port
  endgenerate

  always_comb begin
    status                          = '0;
    status[IO_STB_LSB +: NPORTS]    = out_stb;
    status[IO_OVR_LSB +: NPORTS]    = overrun;
  end

  // Unpopulated port indices fall through and read as zero.
  always_comb begin
    io_rdata = '0;
    if (bus_rd) begin
      if (stat_sel) begin
        io_rdata = status;
      end else begin
        for (int i = 0; i < NPORTS; i++) begin
          if (port_idx == IO_IDX_BITS'(i)) io_rdata = sync_bus[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef IO_IRQ_EN
  assign irq = |irq_flag;
`else
  assign irq = 1'b0;
`endif

endmodule : io_port_unit
`default_nettype wire

// File: tb/tb_io_port_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_port_unit
// Brief    : Directed scoreboard bench for io_port_unit.
// Revision : 1.0
// ============================================================================
module tb_io_port_unit;

  localparam int W = 8;
  localparam int N = 4;

  localparam int K_RD   = 0;
  localparam int K_PORT = 1;
  localparam int K_ALL  = 2;
  localparam int K_IRQ  = 3;

`ifdef IO_IRQ_EN
  localparam logic [63:0] IRQ_EXP = 64'd1;
`else
  localparam logic [63:0] IRQ_EXP = 64'd0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           io_enable = 1'b0;
  logic           io_write = 1'b0;
  logic [2:0]     io_addr = '0;
  logic [W-1:0]   io_wdata = '0;
  logic [W-1:0]   io_rdata;
  logic [N*W-1:0] in_data = '0;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_stb;
  logic [N-1:0]   out_ack = '0;
  logic           irq;
  logic           probe_en = 1'b0;

  typedef struct {
    int          kind;
    int          port;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  io_port_unit #(.WIDTH(W), .NPORTS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_enable (io_enable),
    .io_write  (io_write),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_stb   (out_stb),
    .out_ack   (out_ack),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Monitor: a bus read or a probe is an output event; pop and compare.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [63:0] act;
    if ((io_enable && !io_write) || probe_en) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: nothing queued at %0t", $time);
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_RD:    act = 64'(io_rdata);
          K_PORT:  act = 64'({out_stb[e.port], out_data[e.port*W +: W]});
          K_ALL:   act = 64'({out_stb, out_data});
          default: act = 64'(irq);
        endcase
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [W-1:0] exp, input string nm);
    io_enable = 1'b1;
    io_write  = 1'b0;
    io_addr   = a;
    sb.push_back('{K_RD, 0, 64'(exp), nm});
    tick();
    io_enable = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
    io_enable = 1'b1;
    io_write  = 1'b1;
    io_addr   = a;
    io_wdata  = d;
    tick();
    io_enable = 1'b0;
    io_write  = 1'b0;
  endtask

  task automatic probe(input int kind, input int port, input logic [63:0] exp, input string nm);
    sb.push_back('{kind, port, exp, nm});
    probe_en = 1'b1;
    tick();
    probe_en = 1'b0;
  endtask

  task automatic ack(input int p);
    out_ack[p] = 1'b1;
    tick();
    out_ack[p] = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    probe(K_ALL, 0, 64'h0, "reset_outputs");
    probe(K_IRQ, 0, 64'h0, "reset_irq");
    do_read(3'd4, 8'h00, "reset_status");
    reset = 1'b1;
    tick();

    // Input synchronizer latency
    in_data[1*W +: W] = 8'h3C;
    do_read(3'd1, 8'h00, "sync_edge0");
    do_read(3'd1, 8'h00, "sync_edge1");
    do_read(3'd1, 8'h3C, "sync_edge2");

    // Write / strobe / ack handshake
    do_write(3'd2, 8'h55);
    probe(K_PORT, 2, 64'h155, "hs_latch");
    ack(2);
    probe(K_PORT, 2, 64'h055, "hs_acked");
    do_read(3'd4, 8'h00, "hs_status");

    // Overrun and its clear-on-read
    do_write(3'd0, 8'h11);
    do_write(3'd0, 8'h22);
    probe(K_PORT, 0, 64'h122, "ovr_data");
    do_read(3'd4, 8'h11, "ovr_status1");
    do_read(3'd4, 8'h01, "ovr_status2");
    ack(0);
    probe(K_PORT, 0, 64'h022, "ovr_acked");

    // Write and ack in the same cycle on a pending port
    do_write(3'd3, 8'h33);
    out_ack[3] = 1'b1;
    do_write(3'd3, 8'h77);
    out_ack[3] = 1'b0;
    probe(K_PORT, 3, 64'h177, "wa_data");
    do_read(3'd4, 8'h08, "wa_status");
    ack(3);
    ack(3);
    probe(K_PORT, 3, 64'h077, "ack_idle");

    // Writes to the status address are ignored
    do_write(3'd4, 8'hFF);
    do_write(3'd7, 8'hFF);
    probe(K_ALL, 0, 64'h0_7755_0022, "ign_outputs");
    do_read(3'd4, 8'h00, "ign_status");

    // Input-change interrupt
    do_read(3'd1, 8'h3C, "irq_clr_p1");
    probe(K_IRQ, 0, 64'h0, "irq_idle");
    in_data[0 +: W] = 8'h01;
    tick();
    tick();
    probe(K_IRQ, 0, 64'h0, "irq_pre");
    probe(K_IRQ, 0, IRQ_EXP, "irq_set");
    do_read(3'd0, 8'h01, "irq_read_p0");
    probe(K_IRQ, 0, 64'h0, "irq_cleared");

    // Reset asserted mid-handshake
    in_data = {N{8'hA5}};
    do_write(3'd1, 8'h99);
    probe(K_PORT, 1, 64'h199, "rst_pre");
    #2;
    reset = 1'b0;
    probe(K_ALL, 0, 64'h0, "rst_outputs");
    probe(K_IRQ, 0, 64'h0, "rst_irq");
    do_read(3'd0, 8'h00, "rst_rdata");
    do_read(3'd4, 8'h00, "rst_status");
    reset = 1'b1;
    tick();
    tick();
    do_read(3'd0, 8'hA5, "rst_resync");

    tick();
    tick();
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_io_port_unit
`default_nettype wire
